// File: rtl/rdback_serializer_if.sv
// rtl/rdback_serializer_if.sv - host-bound word stream between the serializer and the link
interface rdback_serializer_if #(
    parameter int OUT_WIDTH = 32
);
    logic [OUT_WIDTH-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/rdback_serializer.sv
// rtl/rdback_serializer.sv - drains N readback bursts and narrows each into OUT_WIDTH-bit stream words
module rdback_serializer #(
    parameter int DQ_WIDTH  = 64,
    parameter int OUT_WIDTH = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdback_fifo_empty,
    output logic                    rdback_fifo_rden,
    input  logic [4*DQ_WIDTH-1:0]   rdback_data,
    input  logic                    len_valid,
    input  logic [LEN_WIDTH-1:0]    len_bursts,
    output logic                    busy,
    output logic                    done,
    rdback_serializer_if.master     tx
);
    localparam int BURST_W = 4 * DQ_WIDTH;
    localparam int WORDS   = BURST_W / OUT_WIDTH;
    localparam int WIDX_W  = $clog2(WORDS);
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t                         state_q;
    logic [LEN_WIDTH-1:0]           rem_q;
    logic [WIDX_W-1:0]              widx_q;
    logic [BURST_W-1:0]             sreg_q;
    logic                           busy_q;
    logic                           done_q;
    logic [WORDS-1:0][OUT_WIDTH-1:0] words;
    logic                           at_last_word;

    assign words        = sreg_q;
    assign at_last_word = (widx_q == LAST_IDX);

    // Pop is decoded straight from the registered state so the FIFO read is never issued while empty.
    assign rdback_fifo_rden = (state_q == FETCH) && !rdback_fifo_empty;

    assign tx.tx_valid = (state_q == SEND);
    assign tx.tx_data  = (state_q == SEND) ? words[widx_q] : '0;
    assign tx.tx_last  = (state_q == SEND) && at_last_word && (rem_q == '0);
    assign busy        = busy_q;
    assign done        = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            widx_q  <= '0;
            sreg_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (len_valid) begin
                        if (len_bursts != '0) begin
                            rem_q   <= len_bursts;
                            busy_q  <= 1'b1;
                            state_q <= FETCH;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (rdback_fifo_rden) begin
                        rem_q   <= rem_q - LEN_WIDTH'(1);
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    // FIFO data lands one cycle after the pop.
                    sreg_q  <= rdback_data;
                    widx_q  <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (tx.tx_ready) begin
                        if (!at_last_word) begin
                            widx_q <= widx_q + WIDX_W'(1);
                        end else if (rem_q != '0) begin
                            state_q <= FETCH;
                        end else begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rdback_serializer.sv
// tb/tb_rdback_serializer.sv - directed self-checking bench for rdback_serializer
module tb_rdback_serializer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         fifo_empty;
    logic         rden;
    logic [255:0] rdback_data;
    logic         len_valid;
    logic [15:0]  len_bursts;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    rdback_serializer_if #(.OUT_WIDTH(32)) tx_if ();

    rdback_serializer #(.DQ_WIDTH(64), .OUT_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rdback_fifo_empty (fifo_empty),
        .rdback_fifo_rden  (rden),
        .rdback_data       (rdback_data),
        .len_valid         (len_valid),
        .len_bursts        (len_bursts),
        .busy              (busy),
        .done              (done),
        .tx                (tx_if)
    );

    logic [255:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rden) begin
            rdback_data <= mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_q [$];
    bit          last_q [$];
    int          done_cnt = 0, done_cyc = 0, acc_cyc = 0;
    int          rden_cnt = 0, rden_bad = 0, valid_cnt = 0, stab_err = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!tx_if.tx_valid || tx_if.tx_data !== prev_data || tx_if.tx_last !== prev_last))
                stab_err <= stab_err + 1;
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                got_q.push_back(tx_if.tx_data);
                last_q.push_back(tx_if.tx_last);
                acc_cyc <= cyc;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (rden) rden_cnt <= rden_cnt + 1;
            if (rden && fifo_empty) rden_bad <= rden_bad + 1;
            if (tx_if.tx_valid) valid_cnt <= valid_cnt + 1;
            prev_stall <= tx_if.tx_valid && !tx_if.tx_ready;
            prev_data  <= tx_if.tx_data;
            prev_last  <= tx_if.tx_last;
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int b);
        logic [255:0] v;
        for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'(b + i);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic add_exp(input int b);
        for (int k = 0; k < 8; k++)
            exp_q.push_back({8'(b + 4*k + 3), 8'(b + 4*k + 2), 8'(b + 4*k + 1), 8'(b + 4*k)});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input int len);
        len_valid  = 1'b1;
        len_bursts = 16'(len);
        @(posedge clk);
        #1;
        len_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, input bit rnd);
        int n = 0;
        while (!done && n < bound) begin
            @(posedge clk);
            #1;
            tx_if.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        tx_if.tx_ready = 1'b1;
        chk({tag, "_done_seen"}, done, 1);
    endtask

    task automatic check_words(input string tag, input int base);
        int bad_data = 0;
        int bad_last = 0;
        chk({tag, "_word_count"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= got_q.size() || got_q[base + i] !== exp_q[i]) bad_data++;
        for (int i = base; i < got_q.size(); i++)
            if (last_q[i] !== (i - base == exp_q.size() - 1)) bad_last++;
        chk({tag, "_word_data"}, bad_data, 0);
        chk({tag, "_last_flags"}, bad_last, 0);
    endtask

    initial begin
        int gb, db, rb, vb, n, stall_bad;
        rst_n          = 1'b0;
        len_valid      = 1'b0;
        len_bursts     = '0;
        tx_if.tx_ready = 1'b1;
        idle(2);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rden", rden, 0);
        chk("reset_valid", tx_if.tx_valid, 0);
        chk("reset_last", tx_if.tx_last, 0);
        chk("reset_data", tx_if.tx_data, 0);
        rst_n = 1'b1;
        idle(1);

        // Single burst, LSB-first byte ramp
        exp_q.delete();
        push_burst(0);
        add_exp(0);
        gb = got_q.size(); db = done_cnt; rb = rden_cnt;
        start(1);
        n = 1;
        while (!tx_if.tx_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_valid_latency", n, 3);
        wait_done("single", 100, 1'b0);
        idle(2);
        check_words("single", gb);
        chk("single_done_cnt", done_cnt - db, 1);
        chk("single_done_latency", done_cyc - acc_cyc, 1);
        chk("single_rden_cnt", rden_cnt - rb, 1);

        // Three bursts back to back
        exp_q.delete();
        for (int b = 1; b <= 3; b++) begin
            push_burst(32 * b);
            add_exp(32 * b);
        end
        gb = got_q.size(); db = done_cnt; rb = rden_cnt;
        start(3);
        wait_done("multi", 200, 1'b0);
        idle(2);
        check_words("multi", gb);
        chk("multi_done_cnt", done_cnt - db, 1);
        chk("multi_rden_cnt", rden_cnt - rb, 3);

        // Random backpressure
        exp_q.delete();
        push_burst(128);
        add_exp(128);
        gb = got_q.size(); db = done_cnt;
        start(1);
        wait_done("bp", 400, 1'b1);
        idle(2);
        check_words("bp", gb);
        chk("bp_done_cnt", done_cnt - db, 1);
        chk("bp_stability", stab_err, 0);

        // Empty FIFO stall with an ignored mid-transfer length strobe
        exp_q.delete();
        gb = got_q.size(); db = done_cnt; rb = rden_cnt;
        start(2);
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rden !== 1'b0 || busy !== 1'b1) stall_bad++;
            if (i == 10) begin
                len_valid  = 1'b1;
                len_bursts = 16'd5;
            end
            if (i == 11) len_valid = 1'b0;
        end
        chk("stall_rden_busy", stall_bad, 0);
        push_burst(160); add_exp(160);
        push_burst(192); add_exp(192);
        wait_done("stall", 200, 1'b0);
        idle(2);
        check_words("stall", gb);
        chk("stall_done_cnt", done_cnt - db, 1);
        chk("stall_rden_cnt", rden_cnt - rb, 2);

        // Zero-length request
        db = done_cnt; rb = rden_cnt; vb = valid_cnt;
        start(0);
        chk("zero_done_pulse", done, 1);
        idle(1);
        chk("zero_done_single", done, 0);
        idle(3);
        chk("zero_done_cnt", done_cnt - db, 1);
        chk("zero_no_valid", valid_cnt - vb, 0);
        chk("zero_no_rden", rden_cnt - rb, 0);
        chk("zero_busy", busy, 0);

        // Reset during word 4 of burst 1 of 2
        push_burst(7);
        push_burst(77);
        exp_q.delete();
        add_exp(77);
        gb = got_q.size(); db = done_cnt;
        start(2);
        n = 0;
        while (got_q.size() - gb < 4 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_reach_word4", got_q.size() - gb, 4);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", tx_if.tx_valid, 0);
        chk("rst_data", tx_if.tx_data, 0);
        chk("rst_last", tx_if.tx_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rden", rden, 0);
        chk("rst_done", done, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("rst_idle_busy", busy, 0);
        chk("rst_no_done", done_cnt - db, 0);
        gb = got_q.size(); db = done_cnt;
        start(1);
        wait_done("after_rst", 100, 1'b0);
        idle(2);
        check_words("after_rst", gb);
        chk("after_rst_done_cnt", done_cnt - db, 1);

        chk("rden_never_when_empty", rden_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
